cmd_ctrl_sched: RTL and testbench
=================================

# cmd_ctrl_sched

In-order command scheduler between the AXI command FIFO and the execution engines. It pops one command word at a time from the FIFO's valid/ready output, decodes a 4-bit opcode, and dispatches the word to one of NUM_ENG engines over per-engine valid/ready handshakes. It tracks per-engine busy state until each engine reports done, and implements BARRIER and END sequencing. It also reports completion, illegal-opcode and retired-command status to the register block.

## Interface
- DATA_WIDTH, 32, command word width; must equal the command FIFO data width.
- NUM_ENG, 3, number of engines, legal range 1..4.
- CNT_WIDTH, 16, retired-command counter width.

- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- sched_en  in  1  level; fetch is permitted only while high.
- sched_clr  in  1  pulse; clears sched_err and cmd_cnt.
- cmd_buff_ctrl_out_vld  in  1  FIFO head valid.
- cmd_buff_ctrl_out_data  in  DATA_WIDTH  FIFO head word; opcode = bits [DATA_WIDTH-1:DATA_WIDTH-4].
- ctrl_cmd_buff_rdy  out  1  pop strobe to FIFO.
- eng_vld  out  NUM_ENG  one-hot dispatch valid.
- eng_data  out  DATA_WIDTH  latched command word, shared by all engines.
- eng_rdy  in  NUM_ENG  engine accepts dispatch.
- eng_done  in  NUM_ENG  one-cycle completion pulse per engine.
- eng_busy  out  NUM_ENG  per-engine outstanding flag.
- sched_idle  out  1  state is FETCH and eng_busy is 0.
- sched_done  out  1  one-cycle pulse on END retirement.
- sched_err  out  1  sticky; set on an illegal opcode.
- cmd_cnt  out  CNT_WIDTH  retired commands, wraps at 2^CNT_WIDTH.

## Operation
- Opcode map:
  - 0x0 is NOP.
  - 0x1..NUM_ENG dispatches to engine (opcode-1).
  - 0xE is BARRIER.
  - 0xF is END.
  - All other values are illegal, including engine opcodes greater than NUM_ENG.
- FSM states are FETCH, EXEC, WAIT_IDLE. Reset state is FETCH.
- FETCH:
  - ctrl_cmd_buff_rdy = sched_en.
  - On vld & rdy, latch the word into the cmd register and go to EXEC.
- EXEC, engine opcode:
  - Hold until eng_busy[i]==0, then assert eng_vld[i].
  - Hold vld and data stable until eng_rdy[i].
  - On the handshake, set eng_busy[i], retire the command, go to FETCH.
- EXEC, NOP: retire and go to FETCH next cycle.
- EXEC, illegal opcode: set sched_err, retire (counted), go to FETCH.
- EXEC, BARRIER or END: go to WAIT_IDLE.
- WAIT_IDLE:
  - Hold until eng_busy==0.
  - Then retire and go to FETCH.
  - For END, also pulse sched_done that cycle.
- Busy tracking:
  - eng_done[i] clears eng_busy[i] the next cycle.
  - eng_done on an engine that is not busy is ignored.
  - Set and clear on the same engine in the same cycle cannot occur, because dispatch requires busy==0 registered. If it does occur, set wins.
- Retire means cmd_cnt increments by 1, modulo 2^CNT_WIDTH.
- sched_clr has priority over same-cycle err set and cnt increment. The cleared value is 0.
- Deasserting sched_en:
  - Blocks only new fetches.
  - A command in EXEC or WAIT_IDLE completes normally.
  - eng_done continues to clear busy.
- Dispatch is strictly in order. A command for a busy engine blocks the head even if other engines are free.

## Timing
- Reset values:
  - ctrl_cmd_buff_rdy, eng_vld, eng_data, eng_busy, sched_done, sched_err, cmd_cnt are all 0.
  - sched_idle is 1.
- ctrl_cmd_buff_rdy and eng_vld are decoded from registered state. They have no combinational path from vld or eng_rdy inputs.
- Dispatch to an idle engine with eng_rdy tied high:
  - Cycle 0: FIFO pop.
  - Cycle 1: eng_vld and handshake.
  - Cycle 2: next pop.
  - Peak throughput is 1 command per 2 cycles.
- eng_busy rises the cycle after the eng_rdy handshake and falls the cycle after eng_done.
- BARRIER/END with all engines idle:
  - Cycle 1: EXEC.
  - Cycle 2: WAIT_IDLE retire, plus sched_done for END.
  - Cycle 3: FETCH.
- Reset mid-operation: the latched command and busy flags are lost. The FIFO contents are not affected.

## Test plan
- Reset, then sched_en=1 and FIFO empty: all outputs at reset values, ctrl_cmd_buff_rdy=1, sched_idle=1.
- Push 0x1000_00AA, eng_rdy=1: eng_vld=3'b001 with eng_data=0x1000_00AA one cycle after pop; eng_busy[0]=1 until 1 cycle after eng_done[0]; cmd_cnt=1.
- Push 0x1..., then 0x1... again, with eng_done[0] delayed 10 cycles: second eng_vld[0] is held in EXEC until busy clears; FIFO not popped meanwhile.
- Push 0x1..., 0x2..., 0xF...: both dispatches issue; sched_done pulses exactly once, 1 cycle after the later busy clears; cmd_cnt=3.
- Push 0x7... with NUM_ENG=3: no eng_vld; sched_err=1 and sticky; cmd_cnt=1; sched_clr returns sched_err=0 and cmd_cnt=0.
- Drop sched_en during EXEC with eng_rdy=0 for 5 cycles: dispatch completes when eng_rdy=1; ctrl_cmd_buff_rdy stays 0 afterward until sched_en=1.

Source files
------------

// File: rtl/cmd_ctrl_sched_if.sv
// Command-path bundle between the command FIFO head, the scheduler and the engines.
// The master modport is the scheduler view; slave is the FIFO/engine side.
interface cmd_ctrl_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ENG    = 3
);
  logic                  cmd_buff_ctrl_out_vld;
  logic [DATA_WIDTH-1:0] cmd_buff_ctrl_out_data;
  logic                  ctrl_cmd_buff_rdy;
  logic [NUM_ENG-1:0]    eng_vld;
  logic [DATA_WIDTH-1:0] eng_data;
  logic [NUM_ENG-1:0]    eng_rdy;
  logic [NUM_ENG-1:0]    eng_done;

  modport master (
    input  cmd_buff_ctrl_out_vld,
    input  cmd_buff_ctrl_out_data,
    output ctrl_cmd_buff_rdy,
    output eng_vld,
    output eng_data,
    input  eng_rdy,
    input  eng_done
  );

  modport slave (
    output cmd_buff_ctrl_out_vld,
    output cmd_buff_ctrl_out_data,
    input  ctrl_cmd_buff_rdy,
    input  eng_vld,
    input  eng_data,
    output eng_rdy,
    output eng_done
  );
endinterface

// File: rtl/cmd_ctrl_sched.sv
// In-order command scheduler: pops FIFO words, dispatches them to engines,
// tracks per-engine busy state and sequences BARRIER/END commands.
module cmd_ctrl_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ENG    = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sched_en,
  input  logic                 sched_clr,
  cmd_ctrl_sched_if.master     bus,
  output logic [NUM_ENG-1:0]   eng_busy,
  output logic                 sched_idle,
  output logic                 sched_done,
  output logic                 sched_err,
  output logic [CNT_WIDTH-1:0] cmd_cnt
);

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_EXEC      = 2'd1,
    ST_WAIT_IDLE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_ENG     = 3'd1,
    OP_BARRIER = 3'd2,
    OP_END     = 3'd3,
    OP_ILLEGAL = 3'd4
  } op_class_t;

  // Engine opcodes above NUM_ENG fall through to illegal.
  function automatic op_class_t classify(input logic [3:0] op);
    op_class_t cls;
    if (op == 4'h0) begin
      cls = OP_NOP;
    end else if (op == 4'hE) begin
      cls = OP_BARRIER;
    end else if (op == 4'hF) begin
      cls = OP_END;
    end else if (32'(op) <= 32'(NUM_ENG)) begin
      cls = OP_ENG;
    end else begin
      cls = OP_ILLEGAL;
    end
    return cls;
  endfunction

  state_t                state_r;
  state_t                state_nxt_s;
  logic [DATA_WIDTH-1:0] cmd_r;
  logic [NUM_ENG-1:0]    busy_r;
  logic                  err_r;
  logic [CNT_WIDTH-1:0]  cnt_r;

  logic [3:0]            op_s;
  op_class_t             cls_s;
  logic [NUM_ENG-1:0]    sel_s;
  logic                  fetch_rdy_s;
  logic                  cmd_load_s;
  logic [NUM_ENG-1:0]    vld_s;
  logic [NUM_ENG-1:0]    busy_set_s;
  logic                  retire_s;
  logic                  err_set_s;
  logic                  done_s;

  assign op_s  = cmd_r[DATA_WIDTH-1:DATA_WIDTH-4];
  assign cls_s = classify(op_s);

  // One-hot engine select decoded from the latched opcode.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      sel_s[i] = (op_s == 4'(i + 1));
    end
  end

  // Next-state and handshake decode from registered state.
  always_comb begin
    state_nxt_s = state_r;
    fetch_rdy_s = 1'b0;
    cmd_load_s  = 1'b0;
    vld_s       = '0;
    busy_set_s  = '0;
    retire_s    = 1'b0;
    err_set_s   = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_FETCH: begin
        fetch_rdy_s = sched_en;
        if (sched_en && bus.cmd_buff_ctrl_out_vld) begin
          cmd_load_s  = 1'b1;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
        case (cls_s)
          OP_ENG: begin
            // Head blocks while its engine is busy, even if others are free.
            vld_s      = sel_s & ~busy_r;
            busy_set_s = vld_s & bus.eng_rdy;
            if (|busy_set_s) begin
              retire_s    = 1'b1;
              state_nxt_s = ST_FETCH;
            end else begin
              state_nxt_s = ST_EXEC;
            end
          end
          OP_NOP: begin
            retire_s    = 1'b1;
            state_nxt_s = ST_FETCH;
          end
          OP_BARRIER, OP_END: begin
            state_nxt_s = ST_WAIT_IDLE;
          end
          default: begin
            err_set_s   = 1'b1;
            retire_s    = 1'b1;
            state_nxt_s = ST_FETCH;
          end
        endcase
      end
      ST_WAIT_IDLE: begin
        if (busy_r == '0) begin
          retire_s    = 1'b1;
          done_s      = (cls_s == OP_END);
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Command latch; held stable for the whole EXEC/WAIT_IDLE phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r <= '0;
    end else if (cmd_load_s) begin
      cmd_r <= bus.cmd_buff_ctrl_out_data;
    end else begin
      cmd_r <= cmd_r;
    end
  end

  // Busy tracking: done pulses clear, a same-cycle dispatch set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= (busy_r & ~bus.eng_done) | busy_set_s;
    end
  end

  // Sticky error and retire counter; clear overrides same-cycle updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
      cnt_r <= '0;
    end else if (sched_clr) begin
      err_r <= 1'b0;
      cnt_r <= '0;
    end else begin
      err_r <= err_r | err_set_s;
      cnt_r <= retire_s ? (cnt_r + CNT_WIDTH'(1)) : cnt_r;
    end
  end

  assign bus.ctrl_cmd_buff_rdy = fetch_rdy_s;
  assign bus.eng_vld           = vld_s;
  assign bus.eng_data          = cmd_r;
  assign eng_busy              = busy_r;
  assign sched_idle            = (state_r == ST_FETCH) && (busy_r == '0);
  assign sched_done            = done_s;
  assign sched_err             = err_r;
  assign cmd_cnt               = cnt_r;

endmodule

// File: tb/tb_cmd_ctrl_sched.sv
// Bench for cmd_ctrl_sched: FIFO and engine models, a dispatch scoreboard,
// an opcode vector table and hand-written multi-cycle sequences.
module tb_cmd_ctrl_sched;
  localparam int DW = 32;
  localparam int NE = 3;
  localparam int CW = 16;

  typedef struct {
    int          eng;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    int          disp;
    logic        err;
    int          done;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sched_en = 1'b0;
  logic          sched_clr = 1'b0;
  logic [NE-1:0] eng_busy;
  logic          sched_idle;
  logic          sched_done;
  logic          sched_err;
  logic [CW-1:0] cmd_cnt;

  cmd_ctrl_sched_if #(.DATA_WIDTH(DW), .NUM_ENG(NE)) bus ();

  cmd_ctrl_sched #(.DATA_WIDTH(DW), .NUM_ENG(NE), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sched_en   (sched_en),
    .sched_clr  (sched_clr),
    .bus        (bus),
    .eng_busy   (eng_busy),
    .sched_idle (sched_idle),
    .sched_done (sched_done),
    .sched_err  (sched_err),
    .cmd_cnt    (cmd_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] fifo_q[$];
  exp_t        sb_q[$];
  int          pops = 0;
  int          disp_total = 0;
  int          done_cnt = 0;
  int          done_delay = 0;
  logic [NE-1:0] arm = '0;
  int          dcnt[NE];
  vec_t        vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.cmd_buff_ctrl_out_vld  = (fifo_q.size() != 0);
    bus.cmd_buff_ctrl_out_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  // Scoreboard entry is pushed only for opcodes that address an existing engine.
  task automatic push_cmd(input logic [31:0] word);
    int o;
    exp_t e;
    o = int'(word[31:28]);
    fifo_q.push_back(word);
    if (o >= 1 && o <= NE) begin
      e.eng  = o - 1;
      e.data = word;
      sb_q.push_back(e);
    end
    drive_fifo();
  endtask

  // One clock: observe at negedge, update FIFO and engine models after posedge.
  task automatic tick();
    bit pop;
    exp_t e;
    logic [NE-1:0] dn;
    @(negedge clk);
    pop = bus.ctrl_cmd_buff_rdy && bus.cmd_buff_ctrl_out_vld;
    if (bus.eng_vld != '0) chk("vld_onehot", 32'($countones(bus.eng_vld)), 32'd1);
    for (int i = 0; i < NE; i++) begin
      if (bus.eng_vld[i] && bus.eng_rdy[i]) begin
        disp_total++;
        if (sb_q.size() == 0) begin
          chk("disp_unexpected", 32'(i), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("disp_eng", 32'(i), 32'(e.eng));
          chk("disp_data", bus.eng_data, e.data);
        end
        arm[i]  = 1'b1;
        dcnt[i] = done_delay;
      end
    end
    if (sched_done) done_cnt++;
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    drive_fifo();
    dn = '0;
    for (int i = 0; i < NE; i++) begin
      if (arm[i]) begin
        if (dcnt[i] == 0) begin
          dn[i]  = 1'b1;
          arm[i] = 1'b0;
        end else begin
          dcnt[i] = dcnt[i] - 1;
        end
      end
    end
    bus.eng_done = dn;
  endtask

  task automatic pulse_clr();
    sched_clr = 1'b1;
    tick();
    sched_clr = 1'b0;
  endtask

  initial begin
    int d0, dn0, p0, k, clear_tick, done_tick;
    logic [NE-1:0] prev_busy;

    vt[0] = '{32'h1000_00AA, 1, 1'b0, 0};
    vt[1] = '{32'h2000_0001, 1, 1'b0, 0};
    vt[2] = '{32'h3000_0002, 1, 1'b0, 0};
    vt[3] = '{32'h0000_0003, 0, 1'b0, 0};
    vt[4] = '{32'h4000_0004, 0, 1'b1, 0};
    vt[5] = '{32'h7000_0005, 0, 1'b1, 0};
    vt[6] = '{32'hE000_0006, 0, 1'b0, 0};
    vt[7] = '{32'hF000_0007, 0, 1'b0, 1};
    vt[8] = '{32'hD000_0008, 0, 1'b1, 0};
    for (int i = 0; i < NE; i++) dcnt[i] = 0;

    bus.eng_rdy  = '0;
    bus.eng_done = '0;
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.ctrl_cmd_buff_rdy), 32'd0);
    chk("rst_vld", 32'(bus.eng_vld), 32'd0);
    chk("rst_data", bus.eng_data, 32'd0);
    chk("rst_busy", 32'(eng_busy), 32'd0);
    chk("rst_done", 32'(sched_done), 32'd0);
    chk("rst_err", 32'(sched_err), 32'd0);
    chk("rst_cnt", 32'(cmd_cnt), 32'd0);
    chk("rst_idle", 32'(sched_idle), 32'd1);
    rst_n = 1'b1;
    sched_en = 1'b1;
    tick();
    chk("en_rdy", 32'(bus.ctrl_cmd_buff_rdy), 32'd1);
    chk("en_idle", 32'(sched_idle), 32'd1);

    // Opcode table, engines always ready.
    bus.eng_rdy = '1;
    done_delay  = 0;
    for (int v = 0; v < 9; v++) begin
      pulse_clr();
      d0  = disp_total;
      dn0 = done_cnt;
      push_cmd(vt[v].word);
      repeat (12) tick();
      chk($sformatf("v%0d_cnt", v), 32'(cmd_cnt), 32'd1);
      chk($sformatf("v%0d_err", v), 32'(sched_err), 32'(vt[v].err));
      chk($sformatf("v%0d_disp", v), 32'(disp_total - d0), 32'(vt[v].disp));
      chk($sformatf("v%0d_done", v), 32'(done_cnt - dn0), 32'(vt[v].done));
      chk($sformatf("v%0d_idle", v), 32'(sched_idle), 32'd1);
    end

    // Dispatch latency and busy window.
    done_delay = 3;
    pulse_clr();
    push_cmd(32'h1000_00AA);
    tick();
    chk("lat_vld", 32'(bus.eng_vld), 32'd1);
    chk("lat_data", bus.eng_data, 32'h1000_00AA);
    chk("lat_rdy", 32'(bus.ctrl_cmd_buff_rdy), 32'd0);
    chk("lat_busy0", 32'(eng_busy), 32'd0);
    tick();
    chk("lat_busy1", 32'(eng_busy), 32'd1);
    chk("lat_cnt", 32'(cmd_cnt), 32'd1);
    chk("lat_fetch", 32'(bus.ctrl_cmd_buff_rdy), 32'd1);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("lat_busy_hold", 32'(eng_busy), 32'd1);
    end
    tick();
    chk("lat_busy_clr", 32'(eng_busy), 32'd0);
    chk("lat_idle", 32'(sched_idle), 32'd1);

    // Head-of-line blocking behind a busy engine.
    done_delay = 10;
    pulse_clr();
    p0 = pops;
    d0 = disp_total;
    push_cmd(32'h1000_0011);
    push_cmd(32'h1000_0022);
    push_cmd(32'h2000_0033);
    repeat (3) tick();
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("blk_vld", 32'(bus.eng_vld), 32'd0);
      chk("blk_pops", 32'(pops - p0), 32'd2);
    end
    k = 0;
    while (disp_total < d0 + 3 && k < 60) begin
      tick();
      k++;
    end
    chk("blk_drain", 32'(disp_total - d0), 32'd3);
    repeat (15) tick();
    chk("blk_cnt", 32'(cmd_cnt), 32'd3);
    chk("blk_busy", 32'(eng_busy), 32'd0);

    // END waits for both engines; done one cycle after the last busy clears.
    done_delay = 4;
    pulse_clr();
    dn0 = done_cnt;
    d0  = disp_total;
    clear_tick = -1;
    done_tick  = -1;
    push_cmd(32'h1000_0044);
    push_cmd(32'h2000_0045);
    push_cmd(32'hF000_0046);
    prev_busy = eng_busy;
    for (int j = 1; j <= 40; j++) begin
      k = done_cnt;
      tick();
      if (prev_busy != '0 && eng_busy == '0) clear_tick = j;
      if (done_cnt != k) done_tick = j;
      prev_busy = eng_busy;
    end
    chk("end_done_cnt", 32'(done_cnt - dn0), 32'd1);
    chk("end_done_tick", 32'(done_tick), 32'(clear_tick + 1));
    chk("end_disp", 32'(disp_total - d0), 32'd2);
    chk("end_cnt", 32'(cmd_cnt), 32'd3);

    // Clear priority, sticky error.
    done_delay = 0;
    pulse_clr();
    push_cmd(32'h0000_0009);
    tick();
    sched_clr = 1'b1;
    tick();
    sched_clr = 1'b0;
    chk("clr_pri_cnt", 32'(cmd_cnt), 32'd0);
    push_cmd(32'h7000_000A);
    tick();
    sched_clr = 1'b1;
    tick();
    sched_clr = 1'b0;
    chk("clr_pri_err", 32'(sched_err), 32'd0);
    push_cmd(32'h7000_000B);
    repeat (2) tick();
    chk("ill_err", 32'(sched_err), 32'd1);
    chk("ill_cnt", 32'(cmd_cnt), 32'd1);
    repeat (5) tick();
    chk("ill_sticky", 32'(sched_err), 32'd1);
    pulse_clr();
    chk("clr_err", 32'(sched_err), 32'd0);
    chk("clr_cnt", 32'(cmd_cnt), 32'd0);

    // sched_en dropped while a dispatch waits for eng_rdy.
    bus.eng_rdy = '0;
    push_cmd(32'h3000_0055);
    tick();
    sched_en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("en_hold_vld", 32'(bus.eng_vld), 32'd4);
      chk("en_hold_data", bus.eng_data, 32'h3000_0055);
    end
    bus.eng_rdy = '1;
    tick();
    chk("en_disp_cnt", 32'(cmd_cnt), 32'd1);
    push_cmd(32'h1000_0066);
    p0 = pops;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("en_off_rdy", 32'(bus.ctrl_cmd_buff_rdy), 32'd0);
    end
    chk("en_off_pops", 32'(pops - p0), 32'd0);
    sched_en = 1'b1;
    tick();
    chk("en_on_pops", 32'(pops - p0), 32'd1);
    repeat (6) tick();
    chk("en_on_cnt", 32'(cmd_cnt), 32'd2);

    // Done on an idle engine is ignored.
    arm[0]  = 1'b1;
    dcnt[0] = 0;
    repeat (2) tick();
    chk("stray_done_busy", 32'(eng_busy), 32'd0);

    // Asynchronous reset mid-operation drops the command and busy flags.
    done_delay = 20;
    push_cmd(32'h2000_00CC);
    repeat (2) tick();
    chk("mid_busy", 32'(eng_busy), 32'd2);
    rst_n = 1'b0;
    arm   = '0;
    #1;
    chk("mid_rst_busy", 32'(eng_busy), 32'd0);
    chk("mid_rst_data", bus.eng_data, 32'd0);
    chk("mid_rst_cnt", 32'(cmd_cnt), 32'd0);
    chk("mid_rst_idle", 32'(sched_idle), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("end_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("end_fifo_empty", 32'(fifo_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
